// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports and the data-memory port of dmem_arbiter.
// slave: arbiter view; master: requester/memory side view.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_wait;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_wait;

    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_wait, m1_gnt, m1_wait,
        output rdata, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_wait, m1_gnt, m1_wait,
        input  rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin with bounded bursts under contention.
// Optional macro DMEM_ARB_PRIO0_EN gives port 0 fixed priority and never preempts it.
module dmem_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(BURST_MAX) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BURST_MAX - 1);

`ifdef DMEM_ARB_PRIO0_EN
    // Port 0 wins ties, is never preempted; port 1 yields after one contended cycle.
    localparam logic            Tie0     = 1'b1;
    localparam logic            Preempt0 = 1'b0;
    localparam logic [CntW-1:0] Cnt1Max  = '0;
`else
    localparam logic            Tie0     = 1'b0;
    localparam logic            Preempt0 = 1'b1;
    localparam logic [CntW-1:0] Cnt1Max  = CntMax;
`endif

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} owner_e;

    owner_e          owner_q, owner_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_q, last_d;

    logic            gnt0, gnt1;
    logic            req0, req1;
    logic [CntW-1:0] cnt_inc;
    logic [AW-1:0]   addr_mux;
    logic [DW-1:0]   wdata_mux;

    assign req0    = bus.m0_req;
    assign req1    = bus.m1_req;
    assign gnt0    = (owner_q == StGnt0) & req0;
    assign gnt1    = (owner_q == StGnt1) & req1;
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (gnt0) last_d = 1'b0;
        if (gnt1) last_d = 1'b1;

        case (owner_q)
            StIdle: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    owner_d = (Tie0 || last_q) ? StGnt0 : StGnt1;
                end else if (req0) begin
                    owner_d = StGnt0;
                end else if (req1) begin
                    owner_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!req0) begin
                    owner_d = req1 ? StGnt1 : StIdle;
                    cnt_d   = '0;
                end else if (req1 && Preempt0 && (cnt_q >= CntMax)) begin
                    owner_d = StGnt1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StGnt1: begin
                if (!req1) begin
                    owner_d = req0 ? StGnt0 : StIdle;
                    cnt_d   = '0;
                end else if (req0 && (cnt_q >= Cnt1Max)) begin
                    owner_d = StGnt0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                owner_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // The owner's address/data are presented even when it drops req; only we is gated.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        case (owner_q)
            StGnt0: begin
                addr_mux  = bus.m0_addr;
                wdata_mux = bus.m0_wdata;
            end
            StGnt1: begin
                addr_mux  = bus.m1_addr;
                wdata_mux = bus.m1_wdata;
            end
            default: begin
                addr_mux  = '0;
                wdata_mux = '0;
            end
        endcase
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    // Gated by reset so a held request shows no stall while reset is asserted.
    assign bus.m0_wait   = reset & req0 & ~gnt0;
    assign bus.m1_wait   = reset & req1 & ~gnt1;
    assign bus.mem_we    = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/priority sequences, random traffic
// checked against an arithmetic model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned BMAX = 4;
`ifdef DMEM_ARB_PRIO0_EN
    localparam bit P0 = 1'b1;
`else
    localparam bit P0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BMAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Data memory: synchronous write, combinational read, preloaded on the first edge.
    logic [DW-1:0] mem [256];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            mem[8'h20] <= 32'h1234_5678;
            mem_init   <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner -1 idle / 0 / 1, granted cycles in current tenure, last served.
    int            m_owner;
    int            m_tenure;
    int            m_last;
    logic [DW-1:0] exp_mem [256];
    bit            last_g0, last_g1;

    typedef struct {
        logic        r0, w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        g0, g1, we, crd;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(logic r0, logic w0, logic [7:0] a0, logic [31:0] d0,
                                 logic r1, logic w1, logic [7:0] a1, logic [31:0] d1,
                                 logic g0, logic g1, logic we, logic crd, logic [31:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.crd = crd; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [7:0] a1, input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = {24'h0, a0}; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = {24'h0, a1}; bus.m1_wdata = d1;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_last   = 1;
    endtask

    task automatic model_check(input string tag);
        bit            g0, g1, we;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        g0 = (m_owner == 0) && bus.m0_req;
        g1 = (m_owner == 1) && bus.m1_req;
        ea = (m_owner == 0) ? bus.m0_addr : (m_owner == 1) ? bus.m1_addr : '0;
        ed = (m_owner == 0) ? bus.m0_wdata : (m_owner == 1) ? bus.m1_wdata : '0;
        we = (g0 && bus.m0_we) || (g1 && bus.m1_we);
        chk({tag, ".gnt0"}, 64'(bus.m0_gnt), 64'(g0));
        chk({tag, ".gnt1"}, 64'(bus.m1_gnt), 64'(g1));
        chk({tag, ".wait0"}, 64'(bus.m0_wait), 64'(bus.m0_req && !g0));
        chk({tag, ".wait1"}, 64'(bus.m1_wait), 64'(bus.m1_req && !g1));
        chk({tag, ".mem_we"}, 64'(bus.mem_we), 64'(we));
        chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(ea));
        chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(ed));
        if (g0 || g1) chk({tag, ".rdata"}, 64'(bus.rdata), 64'(exp_mem[ea[7:0]]));
        last_g0 = g0;
        last_g1 = g1;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit r0, r1, g0, g1, own, oth;
        int lim;
        r0 = bus.m0_req;
        r1 = bus.m1_req;
        g0 = (m_owner == 0) && r0;
        g1 = (m_owner == 1) && r1;
        if (g0 && bus.m0_we) exp_mem[bus.m0_addr[7:0]] = bus.m0_wdata;
        if (g1 && bus.m1_we) exp_mem[bus.m1_addr[7:0]] = bus.m1_wdata;
        if (m_owner < 0) begin
            m_tenure = 0;
            if (r0 && r1) m_owner = (P0 || m_last == 1) ? 0 : 1;
            else if (r0) m_owner = 0;
            else if (r1) m_owner = 1;
        end else begin
            own = (m_owner == 0) ? r0 : r1;
            oth = (m_owner == 0) ? r1 : r0;
            if (m_owner == 0) lim = P0 ? 1 << 30 : BMAX;
            else lim = P0 ? 1 : BMAX;
            if (!own) begin
                m_owner  = oth ? 1 - m_owner : -1;
                m_tenure = 0;
            end else if (oth && m_tenure + 1 >= lim) begin
                m_owner  = 1 - m_owner;
                m_tenure = 0;
            end else if (m_tenure < (1 << 20)) begin
                m_tenure++;
            end
        end
        if (g0) m_last = 0;
        if (g1) m_last = 1;
    endtask

    // Apply one vector: table expectations and model checked mid-cycle, then one edge.
    task automatic step_vec(input string tag, input vec_t v);
        drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
        @(negedge clk);
        chk({tag, ".tgnt0"}, 64'(bus.m0_gnt), 64'(v.g0));
        chk({tag, ".tgnt1"}, 64'(bus.m1_gnt), 64'(v.g1));
        chk({tag, ".twait0"}, 64'(bus.m0_wait), 64'(v.r0 & ~v.g0));
        chk({tag, ".twait1"}, 64'(bus.m1_wait), 64'(v.r1 & ~v.g1));
        chk({tag, ".twe"}, 64'(bus.mem_we), 64'(v.we));
        if (v.crd) chk({tag, ".trdata"}, 64'(bus.rdata), 64'(v.rd));
        model_check(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input string tag);
        @(negedge clk);
        model_check(tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic r0, r1;
        vec_t v;
        for (int i = 0; i < 256; i++) exp_mem[i] = 32'hA500_0000 | i;
        exp_mem[8'h20] = 32'h1234_5678;
        model_reset();

        // Outputs must be zero under reset even with requests and addresses driven.
        drive(1'b1, 1'b1, 8'h55, 32'h1111_2222, 1'b1, 1'b1, 8'h66, 32'h3333_4444);
        #2;
        chk("rst.gnt0", 64'(bus.m0_gnt), 64'd0);
        chk("rst.gnt1", 64'(bus.m1_gnt), 64'd0);
        chk("rst.wait0", 64'(bus.m0_wait), 64'd0);
        chk("rst.wait1", 64'(bus.m1_wait), 64'd0);
        chk("rst.mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        //             r0 w0 a0     d0            r1 w1 a1     d1     g0 g1 we crd rd
        tbl.push_back(mkv(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 1, 0, 1, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0, 0, 1, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0, 0, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 1, 0, 0, 1, 32'hA5000001));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, P0, !P0, 0, 0, 32'h0));
        tbl.push_back(mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 1, 0, 0, 0, 32'h0));
        // Owner drops with the other port pending: switch on the next edge.
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 0, 1, 32'h12345678));
        // Owner drops with nothing pending: back to idle, so a new request waits a cycle.
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0, 0, 1, 0, 1, 32'h12345678));
        tbl.push_back(mkv(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) step_vec($sformatf("tbl%0d", i), tbl[i]);
        chk("tbl.mem10", 64'(mem[8'h10]), 64'h0000_0000_DEAD_BEEF);

        // Reset in the middle of a port 1 write cycle drops the write.
        v = mkv(0, 0, 8'h00, 32'h0, 1, 1, 8'h30, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0);
        step_vec("rstw.idle", v);
        #3;
        chk("rstw.we_before", 64'(bus.mem_we), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstw.we", 64'(bus.mem_we), 64'd0);
        chk("rstw.gnt1", 64'(bus.m1_gnt), 64'd0);
        chk("rstw.wait1", 64'(bus.m1_wait), 64'd0);
        chk("rstw.addr", 64'(bus.mem_addr), 64'd0);
        chk("rstw.wdata", 64'(bus.mem_wdata), 64'd0);
        @(posedge clk);
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw.mem30", 64'(mem[8'h30]), 64'h0000_0000_A500_0030);
        model_reset();
        v = mkv(1, 0, 8'h40, 32'h0, 1, 0, 8'h41, 32'h0, 0, 0, 0, 0, 32'h0);
        step_vec("tie.idle", v);
        v = mkv(1, 0, 8'h40, 32'h0, 1, 0, 8'h41, 32'h0, 1, 0, 0, 1, 32'hA5000040);
        step_vec("tie.p0", v);
        step_vec("tie.p0b", v);
        v = mkv(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, 0, 0, 32'h0);
        step_vec("tie.drop", v);
        step_vec("tie.idle2", v);

`ifdef DMEM_ARB_PRIO0_EN
        // Port 0 holds indefinitely; port 1 only gets in when it drops, then yields once.
        v = mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0, 0, 0, 0, 32'h0);
        step_vec("prio.idle", v);
        v.g0 = 1'b1;
        for (int i = 0; i < 8; i++) step_vec($sformatf("prio.hold%0d", i), v);
        v = mkv(0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0, 0, 0, 0, 0, 32'h0);
        step_vec("prio.drop", v);
        v.g1 = 1'b1;
        step_vec("prio.m1a", v);
        v = mkv(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0, 1, 0, 0, 32'h0);
        step_vec("prio.m1last", v);
        v.g0 = 1'b1;
        v.g1 = 1'b0;
        step_vec("prio.back0", v);
`endif

        // Random traffic: a waiting request holds its payload; otherwise redraw.
        last_g0 = 1'b0;
        last_g1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!(bus.m0_req && !last_g0)) begin
                r0 = ($urandom_range(0, 99) < 60);
                bus.m0_req   = r0;
                bus.m0_we    = 1'($urandom_range(0, 1));
                bus.m0_addr  = {24'h0, 8'($urandom_range(0, 255))};
                bus.m0_wdata = $urandom;
            end
            if (!(bus.m1_req && !last_g1)) begin
                r1 = ($urandom_range(0, 99) < 60);
                bus.m1_req   = r1;
                bus.m1_we    = 1'($urandom_range(0, 1));
                bus.m1_addr  = {24'h0, 8'($urandom_range(0, 255))};
                bus.m1_wdata = $urandom;
            end
            step_model($sformatf("rnd%0d", i));
        end
        drive(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
        step_model("rnd.end");
        for (int i = 0; i < 256; i += 17)
            chk($sformatf("mem%0d", i), 64'(mem[i]), 64'(exp_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
